alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
Parametrised successor to the combinational ALU-control decoder: decodes alu_op/funct into a 4-bit ALU control code and also executes the operation on WIDTH-bit operands.
- Valid/ready handshake on input and output.
- Single-cycle ops (add/sub/and/or/nor/slt) plus an optional iterative multi-cycle multiply.
- Sits between the ID/EX operand latch and the writeback mux of the MIPS-style datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- MUL_BITS, 1, multiplier bits retired per EXEC cycle; must divide WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept request this cycle
- alu_op  in  2  00 add, 01 sub, 10 use funct, 11 reserved
- funct  in  6  R-type function field, used only when alu_op=10
- operand_a  in  WIDTH  first operand
- operand_b  in  WIDTH  second operand
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- alu_ctrl  out  4  decoded control code of the completed op
- zero  out  1  result == 0
- illegal  out  1  completed op was undecodable
- busy  out  1  multiply in progress (state EXEC)

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- Decode, registered at accept:
  - alu_op=00: add, ctrl 0010. alu_op=01: sub, ctrl 0110.
  - alu_op=10 with funct 100000 add/0010, 100010 sub/0110, 100100 and/0000, 100101 or/0001, 100111 nor/1100, 101010 slt/0111, 011000 mul/1000 (macro-gated).
  - Anything else, including alu_op=11: illegal, ctrl 1111.
- Arithmetic:
  - add/sub wrap modulo 2^WIDTH; no overflow flag.
  - slt: signed two's-complement compare, result 1 or 0, zero-extended.
  - mul: unsigned, low WIDTH bits of the product.
  - Illegal: result 0, illegal=1, zero=1.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. Accept on in_valid&&in_ready.
  - Non-mul accept: compute and register outputs; go to DONE. out_valid is high the cycle after accept (latency 1).
  - Mul accept: latch operands, clear accumulator, go to EXEC.
  - EXEC: busy=1, in_ready=0. Runs exactly WIDTH/MUL_BITS cycles, then loads outputs and goes to DONE. Latency WIDTH/MUL_BITS+1.
  - DONE: out_valid=1. result, alu_ctrl, zero and illegal are held stable until out_ready.
    - out_ready=0: stay in DONE, in_ready=0.
    - out_ready=1, in_valid=0: go to IDLE.
    - out_ready=1, in_valid=1: in_ready=1, so the new request is accepted in the same cycle (back-to-back, one op per cycle for single-cycle ops).
- Input fields are sampled only at accept; changes while not accepted are ignored.
- Reset values: state IDLE; out_valid 0, result 0, alu_ctrl 0000, zero 0, illegal 0, busy 0. in_ready is 1 the cycle after reset.
- Reset mid-EXEC or in DONE aborts the operation; no output is produced for it.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: funct 011000 executes the iterative multiply through EXEC as above.
- Undefined: funct 011000 decodes as illegal (1 cycle, ctrl 1111). The EXEC state and multiplier logic are not synthesised, and busy is tied 0.

Decomposition:
- Shared package/header alu_ctrl_pkg holds:
  - ALUOP_ADD/SUB/RTYPE/RSVD codes
  - FUNCT_ADD/SUB/AND/OR/NOR/SLT/MUL codes
  - ALU_CTRL_* 4-bit codes including ALU_CTRL_ILLEGAL=1111
  - FSM state encodings
- One natural sub-module: alu_iter_mul.
  - Shift-add, MUL_BITS per cycle; start/done interface.
  - Instantiated only under ALU_MUL_EN.

Test Plan:
- alu_op=00, funct=100000, a=5, b=7 → one cycle after accept: out_valid=1, result=12, alu_ctrl=0010, zero=0.
- alu_op=10, funct=100010, a=3, b=3 → result=0, zero=1, ctrl=0110. Then funct=100100 and 100101 with a=0xF0, b=0x3C → 0x30/ctrl 0000, then 0xFC/ctrl 0001.
- funct=101010, a=0xFFFFFFFF, b=1 → result=1 (signed -1<1). Swap operands → result=0. funct=100111, a=0, b=0 → 0xFFFFFFFF, ctrl 1100.
- ALU_MUL_EN, WIDTH=32, MUL_BITS=1, funct=011000, a=6, b=7 → busy high 32 cycles, out_valid on cycle 33, result=42, ctrl=1000. Without the macro → illegal=1, result=0, ctrl=1111 after 1 cycle.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 → same-cycle accept, next result valid the following cycle.
- Assert rst during cycle 10 of a multiply → next cycle: out_valid=0, busy=0, in_ready=1. Then alu_op=11 → illegal=1, ctrl=1111, result=0.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU-control codes, FSM encodings and the alu_op/funct decoder.
// The multiply decode is present only when ALU_MUL_EN is defined.
package alu_ctrl_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  localparam logic [3:0] ALU_CTRL_AND     = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR      = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD     = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB     = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT     = 4'b0111;
  localparam logic [3:0] ALU_CTRL_MUL     = 4'b1000;
  localparam logic [3:0] ALU_CTRL_NOR     = 4'b1100;
  localparam logic [3:0] ALU_CTRL_ILLEGAL = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       illegal;
    logic       is_mul;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_dec_t d;
    d.ctrl    = ALU_CTRL_ILLEGAL;
    d.illegal = 1'b1;
    d.is_mul  = 1'b0;
    case (alu_op)
      ALUOP_ADD: begin d.ctrl = ALU_CTRL_ADD; d.illegal = 1'b0; end
      ALUOP_SUB: begin d.ctrl = ALU_CTRL_SUB; d.illegal = 1'b0; end
      ALUOP_RTYPE: begin
        d.illegal = 1'b0;
        case (funct)
          FUNCT_ADD: d.ctrl = ALU_CTRL_ADD;
          FUNCT_SUB: d.ctrl = ALU_CTRL_SUB;
          FUNCT_AND: d.ctrl = ALU_CTRL_AND;
          FUNCT_OR:  d.ctrl = ALU_CTRL_OR;
          FUNCT_NOR: d.ctrl = ALU_CTRL_NOR;
          FUNCT_SLT: d.ctrl = ALU_CTRL_SLT;
`ifdef ALU_MUL_EN
          FUNCT_MUL: begin d.ctrl = ALU_CTRL_MUL; d.is_mul = 1'b1; end
`endif
          default:   d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
// done is asserted during the final step; product then already includes that step.
module alu_iter_mul #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int STEPS = WIDTH / MUL_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [WIDTH-1:0] partial;
  logic             last;

  always_comb begin
    partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (b_q[i]) partial = partial + (a_q << i);
    end
  end

  assign last    = (cnt_q == CNT_W'(STEPS - 1));
  assign done    = active_q && last;
  assign product = acc_q + partial;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      a_d      = a;
      b_d      = b;
      acc_d    = '0;
    end else if (active_q) begin
      acc_d = acc_q + partial;
      a_d   = a_q << MUL_BITS;
      b_d   = b_q >> MUL_BITS;
      cnt_d = cnt_q + 1'b1;
      if (last) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// ALU control decode plus execute with valid/ready handshake on both sides.
// Define ALU_MUL_EN to build the iterative multiply (funct 011000) and the EXEC state.
module alu_exec_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_ctrl,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  if (WIDTH < 4 || (WIDTH % MUL_BITS) != 0) begin : g_param_check
    $error("alu_exec_ctrl: WIDTH must be >= 4 and divisible by MUL_BITS");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic             zero_q, zero_d, illegal_q, illegal_d;
  alu_dec_t         dec;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign dec       = alu_decode(alu_op, funct);
  // DONE accepts a new request in the same cycle its result is consumed.
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign alu_ctrl  = ctrl_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

`ifdef ALU_MUL_EN
  alu_iter_mul #(.WIDTH(WIDTH), .MUL_BITS(MUL_BITS)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && dec.is_mul),
    .a       (operand_a),
    .b       (operand_b),
    .done    (mul_done),
    .product (mul_product)
  );
  assign busy = (state_q == ST_EXEC);
`else
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign busy        = 1'b0;
`endif

  always_comb begin
    case (dec.ctrl)
      ALU_CTRL_ADD: alu_res = operand_a + operand_b;
      ALU_CTRL_SUB: alu_res = operand_a - operand_b;
      ALU_CTRL_AND: alu_res = operand_a & operand_b;
      ALU_CTRL_OR:  alu_res = operand_a | operand_b;
      ALU_CTRL_NOR: alu_res = ~(operand_a | operand_b);
      ALU_CTRL_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      default:      alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    ctrl_d    = ctrl_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_EXEC: begin
        if (mul_done) begin
          state_d   = ST_DONE;
          result_d  = mul_product;
          ctrl_d    = ALU_CTRL_MUL;
          zero_d    = (mul_product == '0);
          illegal_d = 1'b0;
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      if (dec.is_mul) begin
        state_d = ST_EXEC;
      end else begin
        state_d   = ST_DONE;
        result_d  = alu_res;
        ctrl_d    = dec.ctrl;
        zero_d    = (alu_res == '0);
        illegal_d = dec.illegal;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      ctrl_q    <= 4'b0000;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      ctrl_q    <= ctrl_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
